// File: rtl/score_hex_driver.sv
// Six-digit score latch driving active-low 7-segment displays, blinking the display on each score change.
// Optional leading-zero blanking is enabled by defining SCORE_BLANK_EN.
module score_hex_driver #(
  parameter int unsigned FLASH_DIV   = 12500000,
  parameter int unsigned FLASH_COUNT = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] digit4,
  input  logic [3:0] digit5,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       busy,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5
);

  localparam int unsigned DIV_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam int unsigned BLK_W = $clog2(FLASH_COUNT + 1);
  localparam int unsigned SCORE_W = 24;

  typedef enum logic [1:0] {IDLE, FLASH_OFF, FLASH_ON} state_e;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     per_q, per_d;
  logic [BLK_W-1:0]     blk_q, blk_d;
  logic [SCORE_W-1:0]   score_q, score_d;

  logic [SCORE_W-1:0]   score_in;
  logic                 load;
  logic                 per_done;
  logic [BLK_W-1:0]     blk_inc;
  logic [6:0]           hex_c [6];
  logic [5:0]           blank;

  assign score_in = {digit5, digit4, digit3, digit2, digit1, digit0};
  assign load     = in_valid && in_ready;
  assign per_done = (per_q == DIV_W'(FLASH_DIV - 1));
  assign blk_inc  = blk_q + BLK_W'(1);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b0111111;
    endcase
  endfunction

  // State, counters and score latch
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      per_q   <= '0;
      blk_q   <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      blk_q   <= blk_d;
      score_q <= score_d;
    end
  end

  // Next state; an identical score is accepted but causes no flash
  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    blk_d   = blk_q;
    score_d = score_q;
    case (state_q)
      IDLE: begin
        if (load && (score_in != score_q)) begin
          score_d = score_in;
          per_d   = '0;
          blk_d   = '0;
          state_d = FLASH_OFF;
        end
      end
      FLASH_OFF: begin
        if (per_done) begin
          per_d   = '0;
          state_d = FLASH_ON;
        end else begin
          per_d = per_q + DIV_W'(1);
        end
      end
      FLASH_ON: begin
        if (per_done) begin
          per_d   = '0;
          blk_d   = blk_inc;
          state_d = (blk_inc == BLK_W'(FLASH_COUNT)) ? IDLE : FLASH_OFF;
        end else begin
          per_d = per_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: handshake flags and segment decode with optional zero blanking
  always_comb begin
    in_ready = (state_q == IDLE) && !reset;
    busy     = ((state_q == FLASH_OFF) || (state_q == FLASH_ON)) && !reset;
    blank    = '0;
`ifdef SCORE_BLANK_EN
    blank[5] = (score_q[23:20] == 4'd0);
    for (int i = 4; i >= 1; i--) begin
      blank[i] = blank[i+1] && (score_q[4*i +: 4] == 4'd0);
    end
`endif
    for (int i = 0; i < 6; i++) begin
      if ((state_q == FLASH_OFF) || blank[i]) begin
        hex_c[i] = 7'b1111111;
      end else begin
        hex_c[i] = seg7(score_q[4*i +: 4]);
      end
    end
  end

  assign hex0 = hex_c[0];
  assign hex1 = hex_c[1];
  assign hex2 = hex_c[2];
  assign hex3 = hex_c[3];
  assign hex4 = hex_c[4];
  assign hex5 = hex_c[5];

endmodule

// File: tb/tb_score_hex_driver.sv
// Bench for score_hex_driver with FLASH_DIV=2, FLASH_COUNT=2: per-cycle expectations queued and checked on the falling edge.
module tb_score_hex_driver;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] din;
  logic        in_valid;
  logic        in_ready;
  logic        busy;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  always #5 clock = ~clock;

  score_hex_driver #(.FLASH_DIV(2), .FLASH_COUNT(2)) dut (
    .clock   (clock),
    .reset   (reset),
    .digit0  (din[3:0]),
    .digit1  (din[7:4]),
    .digit2  (din[11:8]),
    .digit3  (din[15:12]),
    .digit4  (din[19:16]),
    .digit5  (din[23:20]),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .busy    (busy),
    .hex0    (hex0),
    .hex1    (hex1),
    .hex2    (hex2),
    .hex3    (hex3),
    .hex4    (hex4),
    .hex5    (hex5)
  );

  typedef struct {
    logic [23:0] score;
    bit          flash;
  } vec_t;

  typedef struct {
    bit          busy;
    bit          ready;
    bit          chk_hex;
    logic [41:0] hex;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [23:0] cur;
  vec_t        tbl[8];

  function automatic logic [6:0] tb_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  function automatic logic [41:0] exp_hex(input logic [23:0] s, input bit off);
    logic [41:0] r;
    logic [3:0]  dg;
    bit          lead;
    bit          blk;
    lead = 1'b1;
    r    = '0;
    for (int i = 5; i >= 0; i--) begin
      dg = s[4*i +: 4];
`ifdef SCORE_BLANK_EN
      blk = lead && (dg == 4'd0) && (i != 0);
      if (dg != 4'd0) lead = 1'b0;
`else
      blk  = 1'b0;
      lead = 1'b0;
`endif
      r[7*i +: 7] = (off || blk) ? 7'b1111111 : tb_seg(dg);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input bit b, input bit rdy, input bit ch, input logic [23:0] s,
                      input bit off, input string nm);
    exp_t e;
    e.busy    = b;
    e.ready   = rdy;
    e.chk_hex = ch;
    e.hex     = exp_hex(s, off);
    e.name    = nm;
    sb.push_back(e);
  endtask

  // Eight busy cycles: off,off,on,on,off,off,on,on; then one idle cycle
  task automatic flash_seq(input logic [23:0] s);
    for (int c = 0; c < 8; c++) begin
      push(1'b1, 1'b0, 1'b1, s, (c % 4) < 2, "flash");
      tick();
    end
    cur = s;
    push(1'b0, 1'b1, 1'b1, cur, 1'b0, "idle_after");
    tick();
  endtask

  task automatic run_load(input logic [23:0] s, input bit flash);
    din      = s;
    in_valid = 1'b1;
    push(1'b0, 1'b1, 1'b1, cur, 1'b0, "load_cycle");
    tick();
    in_valid = 1'b0;
    if (flash) begin
      flash_seq(s);
    end else begin
      push(1'b0, 1'b1, 1'b1, cur, 1'b0, "same_score");
      tick();
      push(1'b0, 1'b1, 1'b1, cur, 1'b0, "same_score2");
      tick();
    end
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [41:0] got;
      e   = sb.pop_front();
      got = {hex5, hex4, hex3, hex2, hex1, hex0};
      checks++;
      if (busy !== e.busy) begin
        errors++;
        $display("FAIL %s busy: got %b want %b at %0t", e.name, busy, e.busy, $time);
      end
      checks++;
      if (in_ready !== e.ready) begin
        errors++;
        $display("FAIL %s in_ready: got %b want %b at %0t", e.name, in_ready, e.ready, $time);
      end
      if (e.chk_hex) begin
        checks++;
        if (got !== e.hex) begin
          errors++;
          $display("FAIL %s hex: got %h want %h at %0t", e.name, got, e.hex, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{24'h000042, 1'b1};
    tbl[1] = '{24'h000042, 1'b0};
    tbl[2] = '{24'h987650, 1'b1};
    tbl[3] = '{24'h00C000, 1'b1};
    tbl[4] = '{24'h00C000, 1'b0};
    tbl[5] = '{24'h000F00, 1'b1};
    tbl[6] = '{24'h000000, 1'b1};
    tbl[7] = '{24'h100000, 1'b1};

    reset    = 1'b1;
    in_valid = 1'b0;
    din      = '0;
    cur      = '0;

    // Reset for two cycles; a concurrent load must be overridden
    tick();
    push(1'b0, 1'b0, 1'b1, 24'h0, 1'b0, "reset1");
    tick();
    din      = 24'h999999;
    in_valid = 1'b1;
    push(1'b0, 1'b0, 1'b1, 24'h0, 1'b0, "reset2");
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    push(1'b0, 1'b1, 1'b1, 24'h0, 1'b0, "post_reset");
    tick();

    for (int k = 0; k < 8; k++) begin
      run_load(tbl[k].score, tbl[k].flash);
    end

    // in_valid held through a flash is taken only once the block is idle
    din      = 24'h111111;
    in_valid = 1'b1;
    push(1'b0, 1'b1, 1'b1, cur, 1'b0, "hold_start");
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) begin
        din      = 24'h123456;
        in_valid = 1'b1;
      end
      push(1'b1, 1'b0, 1'b1, 24'h111111, (c % 4) < 2, "hold_flash");
      tick();
    end
    cur = 24'h111111;
    push(1'b0, 1'b1, 1'b1, cur, 1'b0, "hold_accept");
    tick();
    in_valid = 1'b0;
    flash_seq(24'h123456);

    // Reset in the middle of FLASH_OFF aborts the flash
    din      = 24'h000777;
    in_valid = 1'b1;
    push(1'b0, 1'b1, 1'b1, cur, 1'b0, "abort_load");
    tick();
    in_valid = 1'b0;
    push(1'b1, 1'b0, 1'b1, 24'h000777, 1'b1, "abort_off");
    tick();
    reset = 1'b1;
    push(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, "abort_rst");
    tick();
    reset = 1'b0;
    cur   = '0;
    push(1'b0, 1'b1, 1'b1, cur, 1'b0, "abort_idle");
    tick();
    run_load(24'h000042, 1'b1);

    @(negedge clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_hex_driver.md
SCORE_HEX_DRIVER -- requirements
Module: score_hex_driver

Interface
REQ-001 SHALL have parameter FLASH_DIV, default 12500000, clock cycles per half-blink period (minimum 1).
REQ-002 SHALL have parameter FLASH_COUNT, default 3, number of off/on blink pairs per score change (minimum 1).
REQ-003 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports digit0..digit5  input  4 each  decimal digits of the score; digit0 is the least significant.
REQ-006 SHALL have port in_valid  input  1  the digit inputs are a new score to load.
REQ-007 SHALL have port in_ready  output  1  the block can accept a load this cycle.
REQ-008 SHALL have port busy  output  1  a flash sequence is in progress.
REQ-009 SHALL have ports hex0..hex5  output  7 each  active-low segments {g,f,e,d,c,b,a} for display digit N.

Function
REQ-010 SHALL hold a 24-bit latched score (six 4-bit digits); a load is accepted on a rising edge where in_valid and in_ready are both 1.
REQ-011 in_ready SHALL be 1 exactly when the state is IDLE and reset is low; busy SHALL be 1 exactly in FLASH_OFF or FLASH_ON.
REQ-012 States: IDLE, FLASH_OFF, FLASH_ON.
REQ-013 On an accepted load whose digits differ from the latched score, the block SHALL update the latch, clear the period counter and the blink counter, and enter FLASH_OFF at that edge.
REQ-014 On an accepted load whose digits equal the latched score, the block SHALL stay in IDLE and leave the outputs unchanged.
REQ-015 FLASH_OFF SHALL last exactly FLASH_DIV cycles, then go to FLASH_ON with the period counter cleared.
REQ-016 FLASH_ON SHALL last exactly FLASH_DIV cycles, then increment the blink counter.
REQ-017 After FLASH_ON, the block SHALL return to IDLE if the blink count reaches FLASH_COUNT, otherwise go to FLASH_OFF.
REQ-018 Total busy time per load SHALL be 2*FLASH_DIV*FLASH_COUNT cycles.
REQ-019 in_valid while not IDLE SHALL be ignored; the upstream stage holds it until in_ready is 1.
REQ-020 hex outputs SHALL be a combinational decode of the latch and state, so a change is visible directly after the edge that caused it (zero-cycle output latency).
REQ-021 In FLASH_OFF all hex outputs SHALL be 7'b1111111; in IDLE and FLASH_ON they SHALL show the decoded latched digits.
REQ-022 Decode table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-023 A digit value of 10-15 SHALL display a dash (0111111) and SHALL NOT affect blanking.
REQ-024 Counters SHALL be sized for FLASH_DIV and FLASH_COUNT and SHALL never wrap inside a sequence.

Reset
REQ-025 With reset high at an edge: the latch SHALL clear to 0, the state SHALL go to IDLE, and both counters SHALL clear to 0; reset SHALL override a concurrent load.
REQ-026 While reset is high, in_ready and busy SHALL be 0.
REQ-027 After reset, hex0 SHALL show 0 and hex1..hex5 SHALL follow REQ-029/REQ-030.
REQ-028 Reset during a flash SHALL abort it on that edge.

Configuration
REQ-029 With macro SCORE_BLANK_EN defined, leading zeros SHALL be blanked to 1111111, scanning from digit5 down to the first non-zero digit; hex0 SHALL never be blanked.
REQ-030 Without SCORE_BLANK_EN, all six digits SHALL always be decoded, including leading zeros.

Verification (FLASH_DIV=2, FLASH_COUNT=2)
REQ-031 Reset for 2 cycles -> in_ready=0 during reset; then in_ready=1, busy=0, hex0=1000000; hex1..5=1111111 with blanking, 1000000 without.
REQ-032 Load 000042 -> busy=1 for exactly 8 cycles, with the pattern off,off,on,on,off,off,on,on; in_ready is 1 again in cycle 9; hex1=0011001 and hex0=0100100.
REQ-033 Load 000042 again from IDLE -> busy stays 0 and the outputs are unchanged.
REQ-034 Hold in_valid with 123456 during a flash -> accepted only on the first cycle in_ready=1, then a full 8-cycle flash runs.
REQ-035 Assert reset mid-FLASH_OFF -> on the next edge the state is IDLE and the latch is 0.
REQ-036 Load digit3=12 with the others 0 -> hex3=0111111; with blanking, hex5 and hex4 are blank while hex2..hex0 show 0.
